// File: rtl/avalon_wait_ram.sv
// Avalon-MM word memory with a fixed number of waitrequest stall cycles per
// transaction and a side-band preload port for loading program words.
module avalon_wait_ram #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [ADDR_BITS-1:0] inst_addr,
  input  logic [31:0] instruction,
  output logic        protocol_err
);

  localparam int IW    = ADDR_BITS - 2;
  localparam int DEPTH = 2 ** IW;
  // The IDLE cycle already counts as one stall cycle, so WAIT covers the rest.
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("avalon_wait_ram: WAIT_CYCLES must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic [31:0] mem [DEPTH];

  logic          req;
  logic [IW-1:0] bus_idx;
  logic [IW-1:0] pre_idx;
  logic [IW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic [3:0]    lat_be;
  logic          lat_write;

  logic          start;
  logic          enter_done;
  logic          abort;
  logic          commit;
  logic [IW-1:0] rd_idx;
  logic          rd_op;

  logic unused_bits;

  assign req     = read | write;
  assign bus_idx = address[ADDR_BITS-1:2];
  assign pre_idx = inst_addr[ADDR_BITS-1:2];
  assign unused_bits = &{1'b0, address[31:ADDR_BITS], address[1:0], inst_addr[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    waitrequest = req && (state != ST_DONE);
    start       = (state == ST_IDLE) && req;
    enter_done  = (state != ST_DONE) && (state_next == ST_DONE);
    abort       = (state == ST_WAIT) && !req;
    commit      = (state == ST_DONE) && lat_write;
    // With a single stall cycle DONE is entered straight from IDLE, before the latch.
    rd_idx      = (state == ST_IDLE) ? bus_idx : lat_idx;
    rd_op       = (state == ST_IDLE) ? !write : !lat_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_idx   <= '0;
      lat_data  <= 32'd0;
      lat_be    <= 4'd0;
      lat_write <= 1'b0;
    end else if (start) begin
      lat_idx   <= bus_idx;
      lat_data  <= writedata;
      lat_be    <= byteenable;
      lat_write <= write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (enter_done && rd_op) begin
      readdata <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if ((read && write) || abort) begin
      protocol_err <= 1'b1;
    end
  end

  // Preload is applied last so it overrides a bus write to the same word.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
        end
      end
    end
    if (inst_input) begin
      mem[pre_idx] <= instruction;
    end
  end

endmodule
